fcvt_unit: RTL

Parametrised, pipelined single-precision float↔32-bit integer conversion unit with valid/ready handshake. It covers signed/unsigned conversion in both directions, three rounding modes, IEEE-style saturation and exception flags. It replaces the fixed-latency, no-handshake `ftoi`/`itof` converters in the FPU pipeline and sits beside the FPU add/mul units on the FPU issue port.

---
 rtl/fcvt_pkg.sv | 73 +++++++
 rtl/fcvt_unit_lzc32.sv | 17 +
 rtl/fcvt_unit.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fcvt_pkg.sv
// fcvt_pkg: shared types and constants for the float<->int conversion unit.
//   fcvt_op_e / fcvt_rm_e : operation and rounding-mode encodings
//   fcvt_s1_t / fcvt_s2_t : payloads after unpack and after align/normalise
//   round_up()            : magnitude round-increment decision
package fcvt_pkg;

    typedef enum logic [1:0] {
        OP_F2I_S = 2'b00,
        OP_F2I_U = 2'b01,
        OP_I2F_S = 2'b10,
        OP_I2F_U = 2'b11
    } fcvt_op_e;

    typedef enum logic [1:0] {
        RM_RNE     = 2'b00,
        RM_RTZ     = 2'b01,
        RM_RMM     = 2'b10,
        RM_RNE_ALT = 2'b11   // reserved encoding, rounds like RNE
    } fcvt_rm_e;

    localparam int unsigned FLT_EXP_W = 8;
    localparam int unsigned FLT_MAN_W = 23;
    localparam int unsigned FLT_SIG_W = 24;
    localparam int unsigned INT_W     = 32;

    localparam logic [7:0] FLT_BIAS = 8'd127;
    // Exponent field of 2^31: hidden bit lands on bit 31 of the integer.
    localparam logic [7:0] EXP_2P31 = FLT_BIAS + 8'd31;
    // Fields at/above this are |x| >= 2^32 (includes Inf/NaN).
    localparam logic [7:0] EXP_BIG  = FLT_BIAS + 8'd32;
    // Fields below this are |x| < 2^-32: only a sticky bit survives.
    localparam logic [7:0] EXP_TINY = FLT_BIAS - 8'd32;

    localparam logic [31:0] SAT_S_POS = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_S_NEG = 32'h8000_0000;
    localparam logic [31:0] SAT_U_POS = 32'hFFFF_FFFF;

    typedef struct packed {
        fcvt_op_e    op;
        fcvt_rm_e    rm;
        logic        sign;
        logic        is_nan;
        logic        is_big;
        logic        is_tiny;
        logic        is_zero;   // F2I: zero/subnormal; I2F: zero operand
        logic        sub_nz;
        logic [5:0]  shamt;     // F2I right-align amount
        logic [31:0] mag;       // F2I: {hidden, mantissa}; I2F: |operand|
    } fcvt_s1_t;

    typedef struct packed {
        fcvt_op_e    op;
        fcvt_rm_e    rm;
        logic        sign;
        logic        is_nan;
        logic        is_big;
        logic        is_zero;
        logic [31:0] body;      // F2I: integer part; I2F: normalised magnitude
        logic        rnd;       // F2I first discarded bit
        logic        stk;       // F2I OR of remaining discarded bits
        logic [5:0]  lz;        // I2F leading-zero count
    } fcvt_s2_t;

    function automatic logic round_up(input fcvt_rm_e rm, input logic lsb,
                                      input logic rnd, input logic stk);
        case (rm)
            RM_RTZ:  return 1'b0;
            RM_RMM:  return rnd;
            default: return rnd & (stk | lsb);
        endcase
    endfunction

endpackage

// File: rtl/fcvt_unit_lzc32.sv
// lzc32: 32-bit leading-zero counter.
//   data_i : value to scan
//   cnt_o  : number of leading zeros, 32 when data_i is zero
module lzc32 (
    input  logic [31:0] data_i,
    output logic [5:0]  cnt_o
);

    // Ascending scan so the highest set bit writes last and wins.
    always_comb begin
        cnt_o = 6'd32;
        for (int unsigned i = 0; i < 32; i++) begin
            if (data_i[i]) cnt_o = 6'(31 - i);
        end
    end

endmodule

// File: rtl/fcvt_unit.sv
// fcvt_unit: pipelined binary32 <-> 32-bit integer converter, valid/ready.
//   clk, rstn           : clock, asynchronous active-low reset
//   in_valid/in_ready   : request handshake (in_ready = global advance)
//   in_op, in_rm        : operation and rounding mode
//   in_data, in_tag     : operand and opaque tag
//   out_valid/out_ready : result handshake
//   out_data, out_tag   : result and its tag
//   out_nv, out_nx      : invalid and inexact flags
// Datapath: unpack -> [reg if STAGES>=2] -> align/LZC/normalise
//           -> [reg if STAGES==3] -> round/saturate/pack -> output reg.
module fcvt_unit
    import fcvt_pkg::*;
#(
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [1:0]       in_rm,
    input  logic [31:0]      in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_nv,
    output logic             out_nx
);

    logic adv;

    logic             out_valid_q;
    logic [31:0]      out_data_q;
    logic [TAG_W-1:0] out_tag_q;
    logic             out_nv_q;
    logic             out_nx_q;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    // ---------------- unpack ----------------
    fcvt_op_e   op_w;
    logic [7:0] f_exp;
    logic [22:0] f_man;
    fcvt_s1_t   s1_d;

    assign op_w  = fcvt_op_e'(in_op);
    assign f_exp = in_data[30:23];
    assign f_man = in_data[22:0];

    always_comb begin
        s1_d    = '0;
        s1_d.op = op_w;
        s1_d.rm = fcvt_rm_e'(in_rm);
        if (op_w == OP_F2I_S || op_w == OP_F2I_U) begin
            s1_d.sign    = in_data[31];
            s1_d.is_nan  = (f_exp == 8'hFF) && (f_man != '0);
            s1_d.is_big  = (f_exp >= EXP_BIG);
            s1_d.is_zero = (f_exp == 8'd0);
            s1_d.sub_nz  = (f_exp == 8'd0) && (f_man != '0);
            s1_d.is_tiny = (f_exp != 8'd0) && (f_exp < EXP_TINY);
            s1_d.mag     = {8'd0, 1'b1, f_man};
            if (!s1_d.is_big && !s1_d.is_tiny && !s1_d.is_zero)
                s1_d.shamt = 6'(EXP_2P31 - f_exp);
        end else begin
            s1_d.sign    = (op_w == OP_I2F_S) && in_data[31];
            s1_d.mag     = s1_d.sign ? (~in_data + 32'd1) : in_data;
            s1_d.is_zero = (in_data == '0);
        end
    end

    // ---------------- optional register after unpack ----------------
    fcvt_s1_t         s2_in;
    logic             s2_in_v;
    logic [TAG_W-1:0] s2_in_tag;

    generate
        if (STAGES >= 2) begin : g_reg_unpack
            fcvt_s1_t         r_q;
            logic             v_q;
            logic [TAG_W-1:0] tag_q;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    v_q   <= 1'b0;
                    r_q   <= '0;
                    tag_q <= '0;
                end else if (adv) begin
                    v_q   <= in_valid;
                    r_q   <= s1_d;
                    tag_q <= in_tag;
                end
            end

            assign s2_in     = r_q;
            assign s2_in_v   = v_q;
            assign s2_in_tag = tag_q;
        end else begin : g_pass_unpack
            assign s2_in     = s1_d;
            assign s2_in_v   = in_valid;
            assign s2_in_tag = in_tag;
        end
    endgenerate

    // ---------------- align (F2I) / LZC + normalise (I2F) ----------------
    logic [5:0]  lz_w;
    logic [63:0] wide_w;
    logic [63:0] wide_sh_w;
    logic        lost_w;
    fcvt_s2_t    s2_d;

    lzc32 u_lzc (
        .data_i (s2_in.mag),
        .cnt_o  (lz_w)
    );

    // Significand placed so its hidden bit sits at bit 63 (value 2^31);
    // after the right shift, [63:32] is the integer part and [31:0] the
    // fraction. Bits pushed below bit 0 fold into sticky through lost_w.
    assign wide_w    = {s2_in.mag[23:0], 40'd0};
    assign wide_sh_w = wide_w >> s2_in.shamt;
    assign lost_w    = |(wide_w & ~(64'hFFFF_FFFF_FFFF_FFFF << s2_in.shamt));

    always_comb begin
        s2_d         = '0;
        s2_d.op      = s2_in.op;
        s2_d.rm      = s2_in.rm;
        s2_d.sign    = s2_in.sign;
        s2_d.is_nan  = s2_in.is_nan;
        s2_d.is_big  = s2_in.is_big;
        s2_d.is_zero = s2_in.is_zero;
        if (s2_in.op == OP_F2I_S || s2_in.op == OP_F2I_U) begin
            if (s2_in.is_zero) begin
                s2_d.stk = s2_in.sub_nz;
            end else if (s2_in.is_tiny) begin
                s2_d.stk = 1'b1;
            end else begin
                s2_d.body = wide_sh_w[63:32];
                s2_d.rnd  = wide_sh_w[31];
                s2_d.stk  = (|wide_sh_w[30:0]) | lost_w;
            end
        end else begin
            s2_d.body = s2_in.mag << lz_w;
            s2_d.lz   = lz_w;
        end
    end

    // ---------------- optional register after align/normalise ----------------
    fcvt_s2_t         s3_in;
    logic             s3_in_v;
    logic [TAG_W-1:0] s3_in_tag;

    generate
        if (STAGES >= 3) begin : g_reg_shift
            fcvt_s2_t         r_q;
            logic             v_q;
            logic [TAG_W-1:0] tag_q;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    v_q   <= 1'b0;
                    r_q   <= '0;
                    tag_q <= '0;
                end else if (adv) begin
                    v_q   <= s2_in_v;
                    r_q   <= s2_d;
                    tag_q <= s2_in_tag;
                end
            end

            assign s3_in     = r_q;
            assign s3_in_v   = v_q;
            assign s3_in_tag = tag_q;
        end else begin : g_pass_shift
            assign s3_in     = s2_d;
            assign s3_in_v   = s2_in_v;
            assign s3_in_tag = s2_in_tag;
        end
    endgenerate

    // ---------------- round / saturate / pack ----------------
    logic        f_inc;
    logic [32:0] f_mag;
    logic        f_inexact;
    logic        i_inc;
    logic [24:0] i_sig;
    logic [7:0]  i_exp;
    logic [31:0] res_data;
    logic        res_nv;
    logic        res_nx;

    assign f_inc     = round_up(s3_in.rm, s3_in.body[0], s3_in.rnd, s3_in.stk);
    assign f_mag     = {1'b0, s3_in.body} + {32'd0, f_inc};
    assign f_inexact = s3_in.rnd | s3_in.stk;

    assign i_inc = round_up(s3_in.rm, s3_in.body[8], s3_in.body[7], |s3_in.body[6:0]);
    assign i_sig = {1'b0, s3_in.body[31:8]} + {24'd0, i_inc};
    // A rounding carry leaves i_sig = 2^24, whose low 23 bits are already 0.
    assign i_exp = EXP_2P31 - {2'b00, s3_in.lz} + {7'd0, i_sig[24]};

    always_comb begin
        res_data = '0;
        res_nv   = 1'b0;
        res_nx   = 1'b0;
        case (s3_in.op)
            OP_F2I_S: begin
                if (s3_in.is_nan) begin
                    res_data = SAT_S_POS;
                    res_nv   = 1'b1;
                end else if (s3_in.is_big) begin
                    res_data = s3_in.sign ? SAT_S_NEG : SAT_S_POS;
                    res_nv   = 1'b1;
                end else if (!s3_in.sign && f_mag > {1'b0, SAT_S_POS}) begin
                    res_data = SAT_S_POS;
                    res_nv   = 1'b1;
                end else if (s3_in.sign && f_mag > {1'b0, SAT_S_NEG}) begin
                    res_data = SAT_S_NEG;
                    res_nv   = 1'b1;
                end else begin
                    res_data = s3_in.sign ? (~f_mag[31:0] + 32'd1) : f_mag[31:0];
                    res_nx   = f_inexact;
                end
            end
            OP_F2I_U: begin
                if (s3_in.is_nan) begin
                    res_data = SAT_U_POS;
                    res_nv   = 1'b1;
                end else if (s3_in.is_big) begin
                    res_data = s3_in.sign ? 32'd0 : SAT_U_POS;
                    res_nv   = 1'b1;
                end else if (s3_in.sign) begin
                    // Negative values that round to zero are merely inexact.
                    res_data = 32'd0;
                    res_nv   = (f_mag != '0);
                    res_nx   = (f_mag == '0) && f_inexact;
                end else if (f_mag[32]) begin
                    res_data = SAT_U_POS;
                    res_nv   = 1'b1;
                end else begin
                    res_data = f_mag[31:0];
                    res_nx   = f_inexact;
                end
            end
            default: begin
                if (!s3_in.is_zero) begin
                    res_data = {s3_in.sign, i_exp, i_sig[22:0]};
                    res_nx   = |s3_in.body[7:0];
                end
            end
        endcase
    end

    // ---------------- output register ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_nv_q    <= 1'b0;
            out_nx_q    <= 1'b0;
        end else if (adv) begin
            out_valid_q <= s3_in_v;
            out_data_q  <= res_data;
            out_tag_q   <= s3_in_tag;
            out_nv_q    <= res_nv;
            out_nx_q    <= res_nx;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign out_nv    = out_nv_q;
    assign out_nx    = out_nx_q;

endmodule
